// File: rtl/mem_lsu.sv
// Memory-access stage load/store unit: turns ex/mem load/store operations into
// request/grant/response data-bus transactions and stalls the pipeline until each one completes.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i
);

    localparam logic [7:0] EXE_LB  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU = 8'b1110_0101;
    localparam logic [7:0] EXE_SB  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW  = 8'b1110_1011;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      state;
    logic [7:0]  cnt;
    size_t       ld_size;
    logic        ld_signed;
    logic [1:0]  ld_off;
    logic [31:0] ld_data;
    logic        timed_out;

    logic        is_mem;
    logic        is_store;
    logic        is_signed;
    size_t       size;
    logic        misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_fmt;

    always_comb begin
        is_mem    = 1'b1;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_W;
        case (mem_aluop_i)
            EXE_LB:  begin size = SZ_B; is_signed = 1'b1; end
            EXE_LH:  begin size = SZ_H; is_signed = 1'b1; end
            EXE_LW:  size = SZ_W;
            EXE_LBU: size = SZ_B;
            EXE_LHU: size = SZ_H;
            EXE_SB:  begin size = SZ_B; is_store = 1'b1; end
            EXE_SH:  begin size = SZ_H; is_store = 1'b1; end
            EXE_SW:  is_store = 1'b1;
            default: is_mem = 1'b0;
        endcase

        misaligned = is_mem && ((size == SZ_H && mem_addr_i[0]) ||
                                (size == SZ_W && mem_addr_i[1:0] != 2'b00));

        // Store data is replicated across lanes so the slave can pick any enabled lane.
        case (size)
            SZ_B: begin
                req_be    = 4'b0001 << mem_addr_i[1:0];
                req_wdata = {4{mem_reg2_i[7:0]}};
            end
            SZ_H: begin
                req_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{mem_reg2_i[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = mem_reg2_i;
            end
        endcase
        if (!is_store) req_wdata = '0;
    end

    always_comb begin
        rd_byte = 8'(dbus_rdata_i >> {ld_off, 3'b000});
        rd_half = ld_off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (ld_size)
            SZ_B:    rd_fmt = {{24{ld_signed & rd_byte[7]}}, rd_byte};
            SZ_H:    rd_fmt = {{16{ld_signed & rd_half[15]}}, rd_half};
            default: rd_fmt = dbus_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            bus_err_o    <= 1'b0;
            ld_size      <= SZ_W;
            ld_signed    <= 1'b0;
            ld_off       <= '0;
            ld_data      <= '0;
            timed_out    <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem && !misaligned) begin
                        state        <= REQ;
                        cnt          <= '0;
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= is_store;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_be_o    <= req_be;
                        dbus_wdata_o <= req_wdata;
                        ld_size      <= size;
                        ld_signed    <= is_signed;
                        ld_off       <= mem_addr_i[1:0];
                        ld_data      <= '0;
                        timed_out    <= 1'b0;
                    end
                end
                REQ: begin
                    // The cycle budget wins over a grant arriving on its last cycle.
                    if (cnt == TIMEOUT_LAST) begin
                        state      <= DONE;
                        dbus_req_o <= 1'b0;
                        bus_err_o  <= 1'b1;
                        timed_out  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (dbus_gnt_i) begin
                            state      <= WAIT;
                            dbus_req_o <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (dbus_rvalid_i) begin
                        state   <= DONE;
                        ld_data <= dbus_we_o ? 32'd0 : rd_fmt;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state     <= DONE;
                        bus_err_o <= 1'b1;
                        timed_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    dbus_we_o    <= 1'b0;
                    dbus_addr_o  <= '0;
                    dbus_be_o    <= '0;
                    dbus_wdata_o <= '0;
                end
            endcase
        end
    end

    // Pipeline-facing outputs are combinational but forced quiet while reset is held.
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        if (rst) begin
            wd_o = wd_i;
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end else if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                REQ, WAIT: stallreq_o = 1'b1;
                default: begin
                    wreg_o  = wreg_i && !timed_out;
                    wdata_o = ld_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: randomized ops, a bus responder, and a
// retire-side scoreboard compared against a spec-level model.
module tb_mem_lsu;

    localparam logic [7:0] EXE_LB  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU = 8'b1110_0101;
    localparam logic [7:0] EXE_SB  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW  = 8'b1110_1011;
    localparam logic [7:0] EXE_ADD = 8'b0010_0000;
    localparam logic [7:0] EXE_OR  = 8'b0010_0101;
    localparam logic [7:0] EXE_NOP = 8'b0000_0000;
    localparam int         TMO     = 4;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        bit          checkData;
        logic        misalign;
        logic        busErr;
        int          stalls;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          d1;
        int          d2;
        logic [31:0] rdata;
        bit          hang;
    } bus_t;

    logic        clk, rst;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_addr_i, mem_reg2_i, wdata_i, wdata_o;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, wreg_o, stallreq_o, misalign_o, bus_err_o;
    logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
    logic [3:0]  dbus_be_o;

    exp_t expQ[$];
    bus_t busQ[$];
    int   numChecks = 0;
    int   numFails  = 0;
    int   opIdx     = 0;
    bit   opValid   = 0;
    bit   autoBus   = 0;

    mem_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: derives the bus request and writeback result from the op rules.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                 input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                 input int d1, input int d2, input logic [31:0] rdata, input bit hang);
        int    sizeBytes = 0;
        bit    isStore = 0, isSigned = 0, mis;
        int    lane;
        logic [31:0] byteVal, halfVal, loadVal;
        exp_t  e;
        bus_t  b;
        bit    retired = 0;
        case (op)
            EXE_LB:  begin sizeBytes = 1; isSigned = 1; end
            EXE_LH:  begin sizeBytes = 2; isSigned = 1; end
            EXE_LW:  sizeBytes = 4;
            EXE_LBU: sizeBytes = 1;
            EXE_LHU: sizeBytes = 2;
            EXE_SB:  begin sizeBytes = 1; isStore = 1; end
            EXE_SH:  begin sizeBytes = 2; isStore = 1; end
            EXE_SW:  begin sizeBytes = 4; isStore = 1; end
            default: sizeBytes = 0;
        endcase
        lane    = int'(addr % 4);
        mis     = (sizeBytes == 2 && addr % 2 != 0) || (sizeBytes == 4 && addr % 4 != 0);
        byteVal = (rdata >> (8 * lane)) & 32'hFF;
        halfVal = (rdata >> (8 * (lane / 2) * 2)) & 32'hFFFF;
        if (sizeBytes == 1)      loadVal = (isSigned && byteVal >= 128)   ? byteVal + 32'hFFFF_FF00 : byteVal;
        else if (sizeBytes == 2) loadVal = (isSigned && halfVal >= 32768) ? halfVal + 32'hFFFF_0000 : halfVal;
        else                     loadVal = rdata;

        e.wd = wd; e.busErr = 0; e.misalign = 0; e.checkData = 1;
        if (sizeBytes == 0) begin
            e.wreg = wreg; e.wdata = wdata; e.stalls = 0;
        end else if (mis) begin
            e.wreg = 0; e.wdata = 0; e.checkData = 0; e.misalign = 1; e.stalls = 0;
        end else begin
            b.we   = isStore;
            b.addr = addr - (addr % 4);
            if (sizeBytes == 1)      b.be = 4'(1 << lane);
            else if (sizeBytes == 2) b.be = (lane >= 2) ? 4'd12 : 4'd3;
            else                     b.be = 4'd15;
            if (sizeBytes == 1)      b.wdata = (reg2 & 32'hFF) * 32'h0101_0101;
            else if (sizeBytes == 2) b.wdata = (reg2 & 32'hFFFF) * 32'h0001_0001;
            else                     b.wdata = reg2;
            b.d1 = d1; b.d2 = d2; b.rdata = rdata; b.hang = hang;
            busQ.push_back(b);
            if (hang) begin
                e.wreg = 0; e.wdata = 0; e.busErr = 1; e.stalls = 1 + TMO;
            end else begin
                e.wreg = wreg; e.wdata = isStore ? 32'd0 : loadVal; e.stalls = d1 + d2 + 3;
            end
        end
        expQ.push_back(e);

        mem_aluop_i = op; mem_addr_i = addr; mem_reg2_i = reg2;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; opValid = 1;
        for (int i = 0; i < 40 && !retired; i++) begin
            @(negedge clk);
            if (!stallreq_o) retired = 1;
        end
        if (!retired) checkOutput("retire_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        opValid = 0;
        mem_aluop_i = EXE_NOP;
    endtask

    // Monitor: every cycle the pipeline advances, the presented op retires.
    initial begin : monitor
        int   stallCount = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && opValid) begin
                if (stallreq_o) stallCount++;
                else if (expQ.size() == 0) checkOutput("retire_unexpected", 32'd1, 32'd0);
                else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("op%0d_wd", opIdx), 32'(wd_o), 32'(e.wd));
                    checkOutput($sformatf("op%0d_wreg", opIdx), 32'(wreg_o), 32'(e.wreg));
                    if (e.checkData) checkOutput($sformatf("op%0d_wdata", opIdx), wdata_o, e.wdata);
                    checkOutput($sformatf("op%0d_misalign", opIdx), 32'(misalign_o), 32'(e.misalign));
                    checkOutput($sformatf("op%0d_bus_err", opIdx), 32'(bus_err_o), 32'(e.busErr));
                    checkOutput($sformatf("op%0d_stalls", opIdx), 32'(stallCount), 32'(e.stalls));
                    stallCount = 0;
                    opIdx++;
                end
            end
        end
    end

    // Bus responder: grants and answers each request after the planned delays.
    initial begin : responder
        bus_t b;
        bit   dropped;
        dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (rst && autoBus && dbus_req_o) begin
                if (busQ.size() == 0) checkOutput("spurious_req", 32'd1, 32'd0);
                else begin
                    b = busQ.pop_front();
                    checkOutput("req_addr", dbus_addr_o, b.addr);
                    checkOutput("req_we", 32'(dbus_we_o), 32'(b.we));
                    checkOutput("req_be", 32'(dbus_be_o), 32'(b.be));
                    if (b.we) checkOutput("req_wdata", dbus_wdata_o, b.wdata);
                    if (b.hang) begin
                        dropped = 0;
                        for (int i = 0; i < 10 && !dropped; i++) begin
                            @(negedge clk);
                            if (!dbus_req_o) dropped = 1;
                        end
                        checkOutput("timeout_req_drop", 32'(dropped), 32'd1);
                    end else begin
                        for (int i = 0; i < b.d1; i++) begin
                            dbus_rvalid_i = 1'($urandom);
                            dbus_rdata_i  = $urandom;
                            @(negedge clk);
                        end
                        dbus_rvalid_i = 0;
                        dbus_gnt_i    = 1;
                        @(negedge clk);
                        dbus_gnt_i = 0;
                        for (int i = 0; i < b.d2; i++) @(negedge clk);
                        dbus_rvalid_i = 1;
                        dbus_rdata_i  = b.rdata;
                        @(negedge clk);
                        dbus_rvalid_i = 0;
                        dbus_rdata_i  = $urandom;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] opList [10];
        logic [7:0] op;
        logic [31:0] addr;
        opList = '{EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU, EXE_SB, EXE_SH, EXE_SW, EXE_ADD, EXE_OR};

        rst = 0;
        mem_aluop_i = EXE_LW; mem_addr_i = 32'h100; mem_reg2_i = '0;
        wd_i = 5'd9; wreg_i = 1; wdata_i = 32'hDEAD_BEEF;
        #3;
        checkOutput("reset_stallreq", 32'(stallreq_o), 32'd0);
        checkOutput("reset_req", 32'(dbus_req_o), 32'd0);
        checkOutput("reset_wd", 32'(wd_o), 32'd0);
        checkOutput("reset_wreg", 32'(wreg_o), 32'd0);
        checkOutput("reset_wdata", wdata_o, 32'd0);
        checkOutput("reset_bus_err", 32'(bus_err_o), 32'd0);
        mem_aluop_i = EXE_NOP;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        autoBus = 1;

        applyStimulus(EXE_ADD, 32'h0, 32'h0, 5'd3, 1, 32'h1234_5678, 0, 0, 32'h0, 0);
        applyStimulus(EXE_SB, 32'h1003, 32'hAABB_CCDD, 5'd0, 0, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus(EXE_LB, 32'h2001, 32'h0, 5'd4, 1, 32'h0, 0, 0, 32'h0000_8000, 0);
        applyStimulus(EXE_LBU, 32'h2001, 32'h0, 5'd5, 1, 32'h0, 1, 1, 32'h0000_8000, 0);
        applyStimulus(EXE_LH, 32'h2002, 32'h0, 5'd6, 1, 32'h0, 0, 1, 32'h8001_0000, 0);
        applyStimulus(EXE_LW, 32'h3002, 32'h0, 5'd7, 1, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus(EXE_LW, 32'h3000, 32'h0, 5'd8, 1, 32'h0, 0, 0, 32'h0, 1);

        // Reset while the load is waiting for its response.
        autoBus = 0;
        mem_aluop_i = EXE_LW; mem_addr_i = 32'h4000; wd_i = 5'd7; wreg_i = 1;
        @(negedge clk);
        checkOutput("rstmid_idle_stall", 32'(stallreq_o), 32'd1);
        @(negedge clk);
        checkOutput("rstmid_req_high", 32'(dbus_req_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        dbus_gnt_i = 1;
        @(negedge clk);
        dbus_gnt_i = 0;
        checkOutput("rstmid_wait_req", 32'(dbus_req_o), 32'd0);
        checkOutput("rstmid_wait_stall", 32'(stallreq_o), 32'd1);
        #1 rst = 0;
        #1;
        checkOutput("rstmid_stall_low", 32'(stallreq_o), 32'd0);
        checkOutput("rstmid_req_low", 32'(dbus_req_o), 32'd0);
        checkOutput("rstmid_addr_clr", dbus_addr_o, 32'd0);
        checkOutput("rstmid_be_clr", 32'(dbus_be_o), 32'd0);
        mem_aluop_i = EXE_NOP;
        @(posedge clk); #1 rst = 1;
        autoBus = 1;
        applyStimulus(EXE_LW, 32'h4000, 32'h0, 5'd7, 1, 32'h0, 0, 0, 32'hCAFE_F00D, 0);

        for (int n = 0; n < 80; n++) begin
            op   = opList[$urandom_range(0, 9)];
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            applyStimulus(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
                          $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                          $urandom_range(0, 9) == 0);
        end

        repeat (3) @(posedge clk);
        checkOutput("exp_queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("bus_queue_drained", 32'(busQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
